// File: rtl/spectrum_readout_bridge.sv
// Double-buffered bridge from the SFFT bin stream to the 8-bit host bus.
// Frames are captured into the write bank of a ping-pong memory. Each frame is
// tagged with a frame number. The host-visible bank stays frozen while the
// host holds a lock. Malformed frames and overruns are flagged, and a
// one-cycle interrupt is raised when a new frame becomes readable.
module spectrum_readout_bridge #(
  parameter int NFFT_LOG2       = 9,
  parameter int BIN_WIDTH       = 32,
  parameter int FRAME_CNT_WIDTH = 32,
  parameter int ADDR_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [BIN_WIDTH-1:0]  in_data,
  input  logic                  in_last,
  input  logic                  chipselect,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [7:0]            writedata,
  output logic [7:0]            readdata,
  output logic                  frame_irq
);

  localparam int NBINS = 2 ** NFFT_LOG2;
  localparam int BPB   = BIN_WIDTH / 8;
  localparam int FW    = FRAME_CNT_WIDTH / 8;
  localparam int B     = NBINS * BPB;
  localparam logic [ADDR_WIDTH-1:0] BPB_A  = ADDR_WIDTH'(BPB);
  localparam logic [ADDR_WIDTH-1:0] B_A    = ADDR_WIDTH'(B);
  localparam logic [ADDR_WIDTH-1:0] STAT_A = ADDR_WIDTH'(B + FW);
  localparam logic [ADDR_WIDTH-1:0] OVR_A  = ADDR_WIDTH'(B + FW + 1);
  localparam logic [ADDR_WIDTH-1:0] CTRL_A = ADDR_WIDTH'(B + FW + 2);

  // Saturating 8-bit increment for the overrun counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [BIN_WIDTH-1:0]       mem [0:2*NBINS-1];
  logic [NFFT_LOG2-1:0]       idx;
  logic                       rd_bank, lock, valid, pending, frame_err, overrun;
  logic [7:0]                 ovr_cnt;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt, fnum0, fnum1;

  logic last_bin, commit, malformed, wr_en, ctrl_wr, release_lock, eff_lock, swap;
  logic rd_req;
  logic [ADDR_WIDTH-1:0]      addr_div, byte_sel;
  logic [NFFT_LOG2-1:0]       bin_sel;
  logic [FRAME_CNT_WIDTH-1:0] fnum_rd, fn_sh;
  logic [7:0]                 reg_byte;

  logic                 vld_p0, is_mem_p0;
  logic [BIN_WIDTH-1:0] mem_p0, mem_sh;
  logic [7:0]           reg_p0;
  logic [ADDR_WIDTH-1:0] byte_p0;

  // Frame-boundary and host-control decode. Decisions use the lock value
  // registered before any CTRL write in this cycle. A commit that coincides
  // with a release is handled as an unlocked commit.
  assign last_bin     = &idx;
  assign commit       = in_valid & in_last & last_bin;
  assign malformed    = in_valid & (in_last ^ last_bin);
  assign wr_en        = in_valid & ~(last_bin & ~in_last);
  assign ctrl_wr      = chipselect & write & (address == CTRL_A);
  assign release_lock = lock & ctrl_wr & ~writedata[0];
  assign eff_lock     = lock & ~release_lock;
  assign swap         = (commit & ~eff_lock) | (~commit & release_lock & pending);

  assign rd_req   = chipselect & ~write;
  assign addr_div = address / BPB_A;
  assign byte_sel = address % BPB_A;
  assign bin_sel  = addr_div[NFFT_LOG2-1:0];
  assign fnum_rd  = rd_bank ? fnum1 : fnum0;
  assign fn_sh    = fnum_rd >> {address - B_A, 3'b000};
  assign mem_sh   = mem_p0 >> {byte_p0, 3'b000};

  logic unused_bits;
  assign unused_bits = ^{writedata[7:2], addr_div[ADDR_WIDTH-1:NFFT_LOG2]};

  // Register-space byte selected by the host address.
  always_comb begin
    reg_byte = 8'h00;
    if (address >= B_A && address < STAT_A) reg_byte = fn_sh[7:0];
    else if (address == STAT_A) reg_byte = {4'b0, overrun, frame_err, pending, valid};
    else if (address == OVR_A)  reg_byte = ovr_cnt;
    else if (address == CTRL_A) reg_byte = {7'b0, lock};
  end

  // Bin memory: capture writes into the write bank, synchronous host read from the read bank.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{~rd_bank, idx}] <= in_data;
    if (rd_req) begin
      mem_p0    <= mem[{rd_bank, bin_sel}];
      byte_p0   <= byte_sel;
      reg_p0    <= reg_byte;
      is_mem_p0 <= (address < B_A);
    end
  end

  // Stage 0 -> 1: the read request travels alongside the captured data, and
  // the output byte is formed one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0   <= 1'b0;
      readdata <= 8'h00;
    end else begin
      vld_p0 <= rd_req;
      if (vld_p0) readdata <= is_mem_p0 ? mem_sh[7:0] : reg_p0;
    end
  end

  // Capture, commit, bank swap, lock and error bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      rd_bank   <= 1'b0;
      lock      <= 1'b0;
      valid     <= 1'b0;
      pending   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      ovr_cnt   <= 8'h00;
      frame_cnt <= '0;
      fnum0     <= '0;
      fnum1     <= '0;
      frame_irq <= 1'b0;
    end else begin
      frame_irq <= swap;
      if (ctrl_wr) lock <= writedata[0];
      if (ctrl_wr && writedata[1]) begin
        frame_err <= 1'b0;
        overrun   <= 1'b0;
        ovr_cnt   <= 8'h00;
      end
      if (in_valid) idx <= (commit || malformed) ? '0 : idx + 1'b1;
      if (malformed) frame_err <= 1'b1;
      if (commit) begin
        frame_cnt <= frame_cnt + 1'b1;
        if (rd_bank) fnum0 <= frame_cnt;
        else         fnum1 <= frame_cnt;
        if (eff_lock) begin
          if (pending) begin
            overrun <= 1'b1;
            ovr_cnt <= sat_inc8(ovr_cnt);
          end else begin
            pending <= 1'b1;
          end
        end
      end
      if (swap) begin
        rd_bank <= ~rd_bank;
        valid   <= 1'b1;
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spectrum_readout_bridge.sv
// Scoreboard bench for spectrum_readout_bridge with 8 bins of 32 bits.
module tb_spectrum_readout_bridge;
  localparam int NL = 3, BW = 32, FCW = 32, AW = 16;
  localparam int B = 32, STAT_A = 36, OVR_A = 37, CTRL_A = 38;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_last, chipselect, write, frame_irq;
  logic [BW-1:0] in_data;
  logic [AW-1:0] address;
  logic [7:0]    writedata, readdata;

  int n_cmp = 0, n_bad = 0, irq_cnt = 0, irq_base;
  logic [7:0] exp_q[$];

  spectrum_readout_bridge #(.NFFT_LOG2(NL), .BIN_WIDTH(BW), .FRAME_CNT_WIDTH(FCW),
                            .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .chipselect(chipselect), .write(write), .address(address), .writedata(writedata),
    .readdata(readdata), .frame_irq(frame_irq));

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_irq) irq_cnt++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bin_val(input int seed, input int i);
    return 32'(i) * 32'h01010101 + (32'(seed) << 24);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_read_expect(input string tag, input int addr, input logic [7:0] exp);
    logic [7:0] e;
    @(negedge clk);
    chipselect = 1'b1; write = 1'b0; address = AW'(addr);
    @(posedge clk);
    exp_q.push_back(exp);
    @(negedge clk);
    chipselect = 1'b0;
    @(posedge clk);
    #1;
    check_eq({tag, "_sb"}, 64'(exp_q.size()), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq(tag, 64'(readdata), 64'(e));
    end
  endtask

  task automatic host_write(input int addr, input logic [7:0] data);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = AW'(addr); writedata = data;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic send_frame(input int seed, input int nbins, input int last_at, input bit unlock);
    for (int i = 0; i < nbins; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = bin_val(seed, i); in_last = (i == last_at);
      if (unlock && i == last_at) begin
        chipselect = 1'b1; write = 1'b1; address = AW'(CTRL_A); writedata = 8'h00;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic read_bin(input string tag, input int seed, input int i);
    logic [31:0] v;
    v = bin_val(seed, i);
    for (int b = 0; b < 4; b++) host_read_expect(tag, i * 4 + b, 8'(v >> (8 * b)));
  endtask

  task automatic read_fnum(input string tag, input logic [31:0] n);
    for (int b = 0; b < 4; b++) host_read_expect(tag, B + b, 8'(n >> (8 * b)));
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    chipselect = 1'b0; write = 1'b0; address = '0; writedata = '0;
    idle(3);
    check_eq("rst_readdata", 64'(readdata), 64'h0);
    check_eq("rst_irq", 64'(frame_irq), 64'h0);
    reset = 1'b1;
    host_read_expect("rst_status", STAT_A, 8'h00);
    host_read_expect("rst_ctrl", CTRL_A, 8'h00);
    host_read_expect("rst_ovr", OVR_A, 8'h00);

    // Well-formed frame 0.
    send_frame(0, 8, 7, 1'b0);
    idle(2);
    check_eq("t1_irq", 64'(irq_cnt), 64'd1);
    host_read_expect("t1_status", STAT_A, 8'h01);
    read_bin("t1_bin1", 0, 1);
    read_bin("t1_bin7", 0, 7);
    read_fnum("t1_fnum", 0);

    // Locked: two frames, the second overruns the pending one.
    host_write(CTRL_A, 8'h01);
    host_read_expect("t2_ctrl", CTRL_A, 8'h01);
    send_frame(8'h10, 8, 7, 1'b0);
    idle(2);
    host_read_expect("t2_status_pend", STAT_A, 8'h03);
    send_frame(8'h20, 8, 7, 1'b0);
    idle(2);
    host_read_expect("t2_status_ovr", STAT_A, 8'h0B);
    host_read_expect("t2_ovr_cnt", OVR_A, 8'h01);
    check_eq("t2_irq_locked", 64'(irq_cnt), 64'd1);
    read_bin("t2_frozen", 0, 2);
    host_write(CTRL_A, 8'h00);
    idle(2);
    check_eq("t2_irq_unlock", 64'(irq_cnt), 64'd2);
    read_fnum("t2_fnum", 2);
    read_bin("t2_bin3", 8'h20, 3);
    host_read_expect("t2_status_after", STAT_A, 8'h09);

    // Clear sticky flags while setting lock; lock follows bit0.
    host_write(CTRL_A, 8'h03);
    host_read_expect("t5_ctrl", CTRL_A, 8'h01);
    host_read_expect("t5_status", STAT_A, 8'h01);
    host_read_expect("t5_ovr", OVR_A, 8'h00);
    host_write(CTRL_A, 8'h00);
    idle(2);
    check_eq("t5_irq", 64'(irq_cnt), 64'd2);

    // Commit coinciding with unlock while a frame is pending.
    host_write(CTRL_A, 8'h01);
    send_frame(8'h30, 8, 7, 1'b0);
    idle(2);
    host_read_expect("t4_status_pend", STAT_A, 8'h03);
    send_frame(8'h40, 8, 7, 1'b1);
    idle(3);
    check_eq("t4_irq", 64'(irq_cnt), 64'd3);
    host_read_expect("t4_status", STAT_A, 8'h01);
    read_fnum("t4_fnum", 4);
    read_bin("t4_bin5", 8'h40, 5);
    host_read_expect("t4_ctrl", CTRL_A, 8'h00);

    // Last bin without in_last: dropped, capture resumes on next bin.
    send_frame(8'h50, 8, -1, 1'b0);
    idle(2);
    check_eq("nl_irq_none", 64'(irq_cnt), 64'd3);
    send_frame(8'h60, 8, 7, 1'b0);
    idle(2);
    check_eq("nl_irq", 64'(irq_cnt), 64'd4);
    host_read_expect("nl_status", STAT_A, 8'h05);
    read_bin("nl_bin0", 8'h60, 0);
    read_bin("nl_bin7", 8'h60, 7);
    read_fnum("nl_fnum", 5);
    host_read_expect("unmapped39", 39, 8'h00);
    host_read_expect("unmapped100", 100, 8'h00);

    // Reset mid-frame while locked.
    host_write(CTRL_A, 8'h01);
    send_frame(8'h70, 4, -1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("t6_readdata", 64'(readdata), 64'h0);
    check_eq("t6_irq", 64'(frame_irq), 64'h0);
    reset = 1'b1;
    host_read_expect("t6_status", STAT_A, 8'h00);
    host_read_expect("t6_ctrl", CTRL_A, 8'h00);
    host_read_expect("t6_ovr", OVR_A, 8'h00);
    read_fnum("t6_fnum", 0);

    // Early in_last after reset, then a good frame numbered 0.
    irq_base = irq_cnt;
    send_frame(8'h80, 6, 5, 1'b0);
    idle(2);
    check_eq("t3_irq_none", 64'(irq_cnt - irq_base), 64'd0);
    host_read_expect("t3_status_err", STAT_A, 8'h04);
    send_frame(8'h90, 8, 7, 1'b0);
    idle(2);
    check_eq("t3_irq", 64'(irq_cnt - irq_base), 64'd1);
    host_read_expect("t3_status", STAT_A, 8'h05);
    read_fnum("t3_fnum", 0);
    read_bin("t3_bin6", 8'h90, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
